// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling engine.
// Provides the pooling mode enum, accumulator sizing helpers and a
// signed saturation function used by every lane.
package pool_pkg;

  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;

  // Working width for saturation; wide enough for any practical lane.
  localparam int SAT_W = 64;

  // Sum of POOL_SIZE elements cannot overflow this width.
  function automatic int acc_width(input int in_w, input int pool_size);
    return in_w + $clog2(pool_size);
  endfunction

  // Right shift that turns the window sum into the average.
  function automatic int avg_shift(input int pool_size);
    return $clog2(pool_size);
  endfunction

  // Clamp a sign-extended value to the signed range of out_w bits.
  // When the output is at least as wide as the input element, every
  // pooled value already fits, so the value passes through untouched.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] x,
    input int                      in_w,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (out_w >= in_w) return x;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// Single-channel pooling lane: running max or running sum, then shift and saturate.
// Latency: res is combinational on the current beat; accumulator updates on en.
// Backpressure: none here; the parent gates en with the input handshake.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         discard the partial window (wins over en)
//   en          accept one window element
//   first/last  current element opens / closes the window
//   avg         1 = average, 0 = max (already latched by the parent)
//   din         signed element
//   res         saturated result including the current element
module pool_lane
  import pool_pkg::*;
#(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 8,
  parameter int POOL_SIZE    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    first,
  input  logic                    last,
  input  logic                    avg,
  input  logic [INPUT_WIDTH-1:0]  din,
  output logic [OUTPUT_WIDTH-1:0] res
);

  localparam int ACC_W = acc_width(INPUT_WIDTH, POOL_SIZE);
  localparam int SHIFT = avg_shift(POOL_SIZE);

  logic signed [ACC_W-1:0] din_x;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] scaled;
  logic signed [SAT_W-1:0] wide;

  assign din_x = {{(ACC_W-INPUT_WIDTH){din[INPUT_WIDTH-1]}}, din};

  // The first element seeds the accumulator in both modes, so no
  // separate "most negative" initial value is needed for max.
  always_comb begin
    acc_nxt = acc_q;
    if (first) begin
      acc_nxt = din_x;
    end else if (avg) begin
      acc_nxt = acc_q + din_x;
    end else if (din_x > acc_q) begin
      acc_nxt = din_x;
    end
  end

  // Arithmetic shift floors toward negative infinity.
  assign scaled = avg ? (acc_nxt >>> SHIFT) : acc_nxt;
  assign wide   = {{(SAT_W-ACC_W){scaled[ACC_W-1]}}, scaled};
  assign res    = OUTPUT_WIDTH'(sat_signed(wide, INPUT_WIDTH, OUTPUT_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= last ? '0 : acc_nxt;
    end
  end

endmodule

// File: rtl/pool_stream_unit.sv
// Streaming multi-channel max/average pooler over POOL_SIZE-beat windows.
// Latency: result visible one cycle after the final beat is accepted; 1 beat/cycle.
// Backpressure: in_ready drops only while a result is pending and out_ready is low.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   mode                 0 = max, 1 = average; taken from the first beat of a window
//   flush                drop the partial window (and any beat offered this cycle)
//   in_valid/in_ready    input beat handshake, ifm_input packs NUM_CH signed elements
//   out_valid/out_ready  result handshake, ifm_output packs NUM_CH signed results
//   win_done             one-cycle pulse coinciding with a newly loaded result
module pool_stream_unit
  import pool_pkg::*;
#(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 8,
  parameter int POOL_SIZE    = 4,
  parameter int NUM_CH       = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mode,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*INPUT_WIDTH-1:0]  ifm_input,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*OUTPUT_WIDTH-1:0] ifm_output,
  output logic                           win_done
);

  localparam int CNT_W = $clog2(POOL_SIZE);

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  pool_mode_e                     mode_q;
  pool_mode_e                     eff_mode;
  logic                           take;
  logic                           first;
  logic                           last;
  logic                           done;
  logic [NUM_CH*OUTPUT_WIDTH-1:0] lane_res;

  assign in_ready = !(out_valid && !out_ready);

  // A flushed beat still completes the handshake but is discarded.
  assign take  = in_valid && in_ready && !flush;
  assign first = (state_q == S_IDLE);
  assign last  = (cnt_q == CNT_W'(POOL_SIZE - 1));
  assign done  = take && last;

  // The window's opening beat uses the live mode; later beats use the latched one.
  assign eff_mode = first ? pool_mode_e'(mode) : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_ACCUM;
          cnt_d   = CNT_W'(1);
        end
      end
      S_ACCUM: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (take) begin
          if (last) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= POOL_MAX;
    end else if (take && first) begin
      mode_q <= eff_mode;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    pool_lane #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .OUTPUT_WIDTH(OUTPUT_WIDTH),
      .POOL_SIZE   (POOL_SIZE)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (flush),
      .en   (take),
      .first(first),
      .last (last),
      .avg  (eff_mode == POOL_AVG),
      .din  (ifm_input[c*INPUT_WIDTH +: INPUT_WIDTH]),
      .res  (lane_res[c*OUTPUT_WIDTH +: OUTPUT_WIDTH])
    );
  end

  // A new result takes priority over retiring the old one, so a final
  // beat landing on a transfer cycle keeps out_valid high with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      ifm_output <= '0;
      win_done   <= 1'b0;
    end else begin
      win_done <= done;
      if (done) begin
        out_valid  <= 1'b1;
        ifm_output <= lane_res;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_stream_unit.sv
// Self-checking bench for pool_stream_unit with a window-level reference model.
module tb_pool_stream_unit;

  localparam int IW  = 12;
  localparam int OW  = 8;
  localparam int PS  = 4;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [NCH*IW-1:0] ifm_input;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*OW-1:0] ifm_output;
  logic              win_done;

  pool_stream_unit #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .POOL_SIZE   (PS),
    .NUM_CH      (NCH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifm_input (ifm_input),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ifm_output(ifm_output),
    .win_done  (win_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: collected window elements, pending result.
  int wb[PS][NCH];
  int wn       = 0;
  bit wmode    = 0;
  bit m_pend   = 0;
  int m_res[NCH];
  int wd_count = 0;
  int hs_count = 0;

  function automatic int ref_pool(input int ch);
    int r;
    int s;
    if (!wmode) begin
      r = wb[0][ch];
      for (int i = 1; i < PS; i++) if (wb[i][ch] > r) r = wb[i][ch];
    end else begin
      s = 0;
      for (int i = 0; i < PS; i++) s += wb[i][ch];
      r = s / PS;                          // truncates toward zero
      if ((s % PS != 0) && (s < 0)) r--;   // make it a floor
    end
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic logic [NCH*OW-1:0] pack_res();
    logic [NCH*OW-1:0] v;
    v = '0;
    for (int ch = 0; ch < NCH; ch++) v[ch*OW +: OW] = OW'(m_res[ch]);
    return v;
  endfunction

  task automatic drive(input bit v, input bit f, input bit md,
                       input int e0, input int e1, input bit ordy);
    in_valid  = v;
    flush     = f;
    mode      = md;
    ifm_input = {IW'(e1), IW'(e0)};
    out_ready = ordy;
  endtask

  // One clock cycle: check in_ready, advance the model, check outputs.
  task automatic tick();
    bit exp_rdy;
    bit acc_e;
    bit xfer;
    bit exp_wd;
    #1;
    exp_rdy = !(m_pend && !out_ready);
    n_tests++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
    end
    if (in_valid && in_ready) hs_count++;
    acc_e = in_valid && exp_rdy;
    xfer  = m_pend && out_ready;
    @(posedge clk);
    #1;
    exp_wd = 0;
    if (acc_e && !flush) begin
      if (wn == 0) wmode = mode;
      for (int ch = 0; ch < NCH; ch++) wb[wn][ch] = $signed(ifm_input[ch*IW +: IW]);
      wn++;
      if (wn == PS) begin
        for (int ch = 0; ch < NCH; ch++) m_res[ch] = ref_pool(ch);
        m_pend = 1;
        exp_wd = 1;
        wn     = 0;
      end else if (xfer) begin
        m_pend = 0;
      end
    end else begin
      if (flush) wn = 0;
      if (xfer) m_pend = 0;
    end
    if (win_done === 1'b1) wd_count++;
    n_tests++;
    if (out_valid !== m_pend) begin
      n_fail++;
      $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, m_pend);
    end
    n_tests++;
    if (win_done !== exp_wd) begin
      n_fail++;
      $display("FAIL win_done t=%0t got %b want %b", $time, win_done, exp_wd);
    end
    if (m_pend) begin
      n_tests++;
      if (ifm_output !== pack_res()) begin
        n_fail++;
        $display("FAIL ifm_output t=%0t got %h want %h", $time, ifm_output, pack_res());
      end
    end
  endtask

  task automatic idle_flush();
    drive(0, 1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic model_clear();
    wn     = 0;
    m_pend = 0;
    wmode  = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || win_done !== 1'b0 || ifm_output !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state got ov=%b wd=%b out=%h rdy=%b want 0 0 0000 1",
               out_valid, win_done, ifm_output, in_ready);
    end
  endtask

  task automatic test_max();
    int a0[PS];
    int a1[PS];
    a0 = '{3, -7, 12, 5};
    a1 = '{-1, -9, -2, -128};
    for (int i = 0; i < PS; i++) begin
      drive(1, 0, 0, a0[i], a1[i], 1);
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b1 || win_done !== 1'b1 || ifm_output !== 16'hFF0C) begin
      n_fail++;
      $display("FAIL max_window got ov=%b wd=%b out=%h want 1 1 ff0c", out_valid, win_done, ifm_output);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_avg();
    int a0[PS];
    int a1[PS];
    // Average window; mode drops to max after the first beat and is ignored.
    a0 = '{1, 2, 2, 2};
    a1 = '{-1, -2, -2, -2};
    for (int i = 0; i < PS; i++) begin
      drive(1, 0, (i == 0), a0[i], a1[i], 1);
      tick();
    end
    n_tests++;
    if (ifm_output !== 16'hFE01) begin
      n_fail++;
      $display("FAIL avg_floor got %h want fe01", ifm_output);
    end
    // Max window; mode rises to average after the first beat and is ignored.
    a0 = '{4, 8, -4, 1};
    a1 = '{-8, -4, -4, -4};
    for (int i = 0; i < PS; i++) begin
      drive(1, 0, (i != 0), a0[i], a1[i], 1);
      tick();
    end
    n_tests++;
    if (ifm_output !== 16'hFC08) begin
      n_fail++;
      $display("FAIL mode_latch got %h want fc08", ifm_output);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_sat();
    int a0[PS];
    a0 = '{300, 10, 20, 30};
    for (int i = 0; i < PS; i++) begin
      drive(1, 0, 0, a0[i], -400, 1);
      tick();
    end
    n_tests++;
    if (ifm_output !== 16'h807F) begin
      n_fail++;
      $display("FAIL saturate got %h want 807f", ifm_output);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_backpressure();
    logic [NCH*OW-1:0] held;
    for (int i = 0; i < PS; i++) begin
      drive(1, 0, 0, 40 + i, -60 - i, 0);
      tick();
    end
    held = ifm_output;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, $urandom_range(0, 1), $urandom_range(0, 200), $urandom_range(0, 200), 0);
      tick();
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || ifm_output !== held) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d got rdy=%b ov=%b out=%h want 0 1 %h",
                 i, in_ready, out_valid, ifm_output, held);
      end
    end
    drive(1, 0, 0, 7, 7, 1);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready got %b want 1", in_ready);
    end
    tick();
    idle_flush();
  endtask

  task automatic test_back_to_back();
    int hs0;
    int wd0;
    hs0 = hs_count;
    wd0 = wd_count;
    for (int i = 0; i < 3 * PS; i++) begin
      drive(1, 0, $urandom_range(0, 1), int'($urandom_range(0, 300)) - 150,
            int'($urandom_range(0, 300)) - 150, 1);
      tick();
    end
    n_tests++;
    if (hs_count - hs0 != 3 * PS || wd_count - wd0 != 3) begin
      n_fail++;
      $display("FAIL stream got beats=%0d results=%0d want 12 3", hs_count - hs0, wd_count - wd0);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_flush();
    int wd0;
    int a0[PS];
    wd0 = wd_count;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 100, 100, 1);
      tick();
    end
    idle_flush();
    a0 = '{5, 6, 7, 8};
    for (int i = 0; i < PS; i++) begin
      drive(1, 0, 0, a0[i], -a0[i], 1);
      tick();
    end
    n_tests++;
    if (wd_count - wd0 != 1 || ifm_output !== 16'hFB08) begin
      n_fail++;
      $display("FAIL flush_partial got results=%0d out=%h want 1 fb08", wd_count - wd0, ifm_output);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    // A beat offered together with flush must not count toward the window.
    wd0 = wd_count;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 50, 50, 1);
      tick();
    end
    drive(1, 1, 0, 120, 120, 1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, i, -i, 1);
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0 || wd_count != wd0) begin
      n_fail++;
      $display("FAIL flush_beat got ov=%b results=%0d want 0 0", out_valid, wd_count - wd0);
    end
    drive(1, 0, 0, 4, -4, 1);
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || ifm_output !== 16'hFF04) begin
      n_fail++;
      $display("FAIL flush_beat_result got ov=%b out=%h want 1 ff04", out_valid, ifm_output);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < PS; i++) begin
      drive(1, 0, 0, 33, -21, 0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || ifm_output !== '0) begin
      n_fail++;
      $display("FAIL reset_pending got ov=%b out=%h want 0 0000", out_valid, ifm_output);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 90, 90, 1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || ifm_output !== '0) begin
      n_fail++;
      $display("FAIL reset_partial got ov=%b out=%h want 0 0000", out_valid, ifm_output);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < PS; i++) begin
      drive(1, 0, 1, 10, -3, 1);
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b1 || ifm_output !== 16'hFD0A) begin
      n_fail++;
      $display("FAIL reset_recover got ov=%b out=%h want 1 fd0a", out_valid, ifm_output);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_random();
    int e0;
    int e1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        e0 = int'($urandom_range(0, 4095)) - 2048;
        e1 = int'($urandom_range(0, 4095)) - 2048;
      end else begin
        e0 = int'($urandom_range(0, 300)) - 150;
        e1 = int'($urandom_range(0, 300)) - 150;
      end
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 1),
            e0, e1, $urandom_range(0, 9) < 7);
      tick();
    end
    idle_flush();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_max();
    test_avg();
    test_sat();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_stream_unit.md
Name: pool_stream_unit

Overview:
Streaming multi-channel pooling engine. It supersedes the fixed 2x2 max-only pooler with configurable window size, channel count, max/average mode and valid/ready flow control. Each beat carries one window element for NUM_CH channels in parallel. After POOL_SIZE accepted beats, one pooled result per channel is emitted. The block sits between the convolution/activation output stream and the next layer's input buffer.

Parameters:
INPUT_WIDTH, 8, signed element width per channel
OUTPUT_WIDTH, 8, signed result width per channel (saturated)
POOL_SIZE, 4, elements per window (e.g. 2*2, 3*3); must be >= 2; must be a power of two when average mode is used
NUM_CH, 4, channels processed in parallel

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = max, 1 = average; sampled on the first beat of each window
flush  in  1  synchronous; discards the partial window
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
ifm_input  in  NUM_CH*INPUT_WIDTH  packed signed elements, channel c at [c*INPUT_WIDTH +: INPUT_WIDTH]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
ifm_output  out  NUM_CH*OUTPUT_WIDTH  packed signed results, same channel packing
win_done  out  1  single-cycle pulse when the last beat of a window is accepted

Behaviour:
- Reset is asynchronous and active-low: out_valid=0, ifm_output=0, win_done=0, element counter=0, accumulators=0, latched mode=max.
- Handshake:
  - Input accept: acc = in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready). The block stalls only while a result is pending and not being taken.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid stays high, and ifm_output stays stable, until the transfer.
- States:
  - IDLE: cnt=0. On acc, go to ACCUM with cnt=1, and latch mode.
  - ACCUM: cnt increments on each acc.
  - On acc with cnt==POOL_SIZE-1: load the result register, set out_valid, pulse win_done, return cnt to 0 (IDLE).
- Throughput and latency:
  - One beat per cycle when out_ready is held high.
  - Result becomes visible the cycle after the final beat is accepted (latency 1).
  - Back-to-back windows run without bubbles.
- Max mode:
  - Per channel, the first element initialises the running max; later elements replace it if strictly greater (signed compare).
  - The result is saturated to OUTPUT_WIDTH.
- Average mode:
  - Per channel, signed sum in an accumulator of INPUT_WIDTH+$clog2(POOL_SIZE) bits, so no overflow is possible.
  - Result = sum >>> $clog2(POOL_SIZE), an arithmetic shift that rounds toward negative infinity, then saturated to OUTPUT_WIDTH.
- Saturation:
  - Clamp to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - If OUTPUT_WIDTH >= INPUT_WIDTH, results are sign-extended and never clamped.
- mode changes mid-window are ignored until the next window's first beat.
- flush:
  - Clears cnt and accumulators next cycle; the window is discarded with no win_done.
  - flush together with acc in the same cycle: flush wins and the beat is dropped.
  - A pending result (out_valid) is not affected by flush.
- Simultaneous output transfer and final beat accept: out_valid stays 1 and ifm_output is updated to the new result; no lost result.
- Reset asserted mid-window or with a pending output: everything clears immediately; the partial window and pending result are lost.

Decomposition:
- Package pool_pkg holds:
  - typedef enum logic {POOL_MAX=1'b0, POOL_AVG=1'b1} pool_mode_e;
  - a sat_signed function parametrised by input and output widths;
  - localparam helpers for accumulator width.
- One sub-module, pool_lane: a single-channel accumulator with max/sum, shift and saturate. The top instantiates NUM_CH copies via generate and holds the counter, FSM, handshake and output register.

Test Plan:
- POOL_SIZE=4, NUM_CH=2, mode=max:
  - Ch0 beats 3, -7, 12, 5 and ch1 beats -1, -9, -2, -128 -> one cycle after the 4th beat, out_valid=1, ch0=12, ch1=-1, win_done pulsed once.
- mode=avg, ch0 beats 1, 2, 2, 2 (sum 7) -> ch0=1; ch1 beats -1, -2, -2, -2 (sum -7) -> ch1=-2 (rounding toward negative infinity).
- INPUT_WIDTH=12, OUTPUT_WIDTH=8, max mode:
  - ch0 beats 300, 10, 20, 30 -> ch0=127;
  - ch1 beats -400 on all four -> ch1=-128 (saturation).
- Backpressure: hold out_ready=0 after a result -> in_ready=0, ifm_output stable for 5 cycles; raise out_ready -> transfer, in_ready=1 in the same cycle.
- Continuous streaming with out_ready=1 over 3 windows -> 12 beats accepted in 12 cycles, 3 results, no bubbles, and the result-update-on-transfer overlap is exercised.
- Flush and reset:
  - flush after 2 beats, then 4 fresh beats -> only one result, computed from the fresh beats;
  - flush asserted with in_valid -> that beat is not counted;
  - rst_n pulsed low mid-window -> out_valid=0, ifm_output=0 immediately, and the next window computes correctly.
